axis_proxy_arbiter: RTL and testbench
=====================================

Name: axis_proxy_arbiter

Overview:
- Shares the single 512-bit AXI-Stream command channel to the EECD between NUM_REQ independent write requesters (AXI proxies, sequencers, DMA config engines).
- Each requester offers one (address, data) write at a time; the block grants round-robin, builds one framed 512-bit beat per write, and holds it until the downstream TREADY.
- Sits between the requesters and the EECD-facing AXIS link. Unlike a fire-and-forget pulse, it fully honours TREADY.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..8; elaboration error outside that range.
- MARKER_HI, 32'hBEADCAFE, marker placed in TDATA[511:480].
- MARKER_LO, 32'hFADEDBAD, marker placed in TDATA[479:448].

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_addr  in  32*NUM_REQ  flattened AXI addresses; requester i uses [32i+31:32i].
- req_data  in  32*NUM_REQ  flattened write data, same slicing.
- AXIS_TDATA  out  512  framed command beat.
- AXIS_TVALID  out  1  beat valid.
- AXIS_TREADY  in  1  downstream accept.
- frames_sent  out  32  count of beats accepted downstream; wraps at 2^32.
- busy  out  1  high while a beat is pending (state SEND).

Behaviour:
- Reset (async assert, sync-safe release) forces these values:
  - AXIS_TVALID=0, AXIS_TDATA=0, busy=0, frames_sent=0.
  - seq counter=0, rr_ptr=0, state=IDLE.
  - req_ready is 0 while reset is high.
- States are IDLE and SEND.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - req_ready = one-hot(grant) when any valid, else 0. This is combinational from req_valid and state only, never from TREADY.
- On the transfer cycle (req_valid[g] & req_ready[g]), at the next edge:
  - TDATA[31:0]=req_data[g].
  - TDATA[63:32]=req_addr[g].
  - TDATA[95:64]=seq.
  - TDATA[103:96]=g, zero-extended.
  - TDATA[447:104]=0.
  - TDATA[479:448]=MARKER_LO.
  - TDATA[511:480]=MARKER_HI.
  - TVALID=1, busy=1, rr_ptr=(g+1) mod NUM_REQ, state=SEND.
- SEND:
  - req_ready=0 for all requesters.
  - TDATA and TVALID are held stable until AXIS_TREADY=1.
  - On the cycle TVALID&TREADY: next edge sets TVALID=0, busy=0, seq+=1 (wraps), frames_sent+=1 (wraps), state=IDLE.
- Latency: request accept to TVALID high is 1 cycle.
- Throughput: at most one beat per 2 cycles. With TREADY tied high, a sustained single requester sees req_ready every other cycle.
- Fairness: a requester holding valid is granted within NUM_REQ grants.
- Requester deasserting valid before ready: no state change. The grant is recomputed every IDLE cycle and nothing is latched.
- NUM_REQ=1: rr_ptr stays 0 and the id field is always 0.
- TREADY high while TVALID=0: ignored.
- Reset mid-SEND: the pending beat is dropped, TVALID drops asynchronously, and no counter increments.
- Grant decision is not affected by address or data values. No error responses are generated.

Decomposition:
- Package axis_proxy_pkg contains:
  - FRAME_W=512.
  - Field bit offsets: DATA_LSB=0, ADDR_LSB=32, SEQ_LSB=64, ID_LSB=96, MLO_LSB=448, MHI_LSB=480.
  - Default marker constants.
  - The NUM_REQ_MAX=8 limit.
- One sub-module, rr_arbiter (NUM_REQ):
  - Combinational rotating-priority search.
  - Inputs: request vector, pointer. Outputs: one-hot grant, binary index, any_grant.
  - The parent owns rr_ptr and the FSM.

Test Plan:
- Single request: reset, requester 0 presents addr 0x0000_1000, data 0xDEAD_BEEF, TREADY=1 → after 1 cycle, TVALID=1 with TDATA[63:0]=0x0000_1000_DEAD_BEEF, seq=0, id=0, markers correct. TVALID drops next cycle; frames_sent=1.
- Backpressure: TREADY=0 for 10 cycles after TVALID → TDATA and TVALID stable throughout, all req_ready=0. Release TREADY → exactly one beat counted.
- Round-robin, NUM_REQ=4: all four requesters valid continuously, TREADY=1 → id sequence 0,1,2,3,0,1…, seq increments 0,1,2,…, one beat every 2 cycles.
- Pointer wrap with sparse requests: rr_ptr=3, only requesters 1 and 3 valid → grant 3, then 1, then 3.
- Withdrawn request: requester 2 pulses valid for 1 cycle while state is SEND → no grant, no frame, frames_sent unchanged.
- Reset mid-SEND: assert reset while TVALID=1, TREADY=0 → TVALID=0 asynchronously, frames_sent=0, seq=0. The next grant after release goes to requester 0.

Source files
------------

// File: rtl/axis_proxy_arbiter_pkg.sv
// Shared constants for the EECD command-channel proxy arbiter:
// frame geometry, field offsets, default markers and requester limits.
package axis_proxy_pkg;

   localparam int FRAME_W     = 512;

   localparam int DATA_LSB    = 0;
   localparam int ADDR_LSB    = 32;
   localparam int SEQ_LSB     = 64;
   localparam int ID_LSB      = 96;
   localparam int MLO_LSB     = 448;
   localparam int MHI_LSB     = 480;

   localparam logic [31:0] DEF_MARKER_HI = 32'hBEADCAFE;
   localparam logic [31:0] DEF_MARKER_LO = 32'hFADEDBAD;

   localparam int NUM_REQ_MAX = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_t;

   // Width of a requester index; a single requester still gets a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_proxy_arbiter_if.sv
// Requester-side handshake bundle plus the EECD-facing AXIS link.
// The master modport is the arbiter itself; the slave modport is the
// surrounding environment (requesters and downstream sink).
interface axis_proxy_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] req_addr;
   logic [32*NUM_REQ-1:0] req_data;
   logic [511:0]          AXIS_TDATA;
   logic                  AXIS_TVALID;
   logic                  AXIS_TREADY;

   modport master (
      input  req_valid, req_addr, req_data, AXIS_TREADY,
      output req_ready, AXIS_TDATA, AXIS_TVALID
   );

   modport slave (
      output req_valid, req_addr, req_data, AXIS_TREADY,
      input  req_ready, AXIS_TDATA, AXIS_TVALID
   );
endinterface

// File: rtl/axis_proxy_arbiter_rr.sv
// Combinational rotating-priority search: the first asserted request at or
// after ptr (wrapping) wins. Pure function of req and ptr, no state.
module rr_arbiter
   import axis_proxy_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_grant
);

   logic [IDX_W-1:0] cand;

   // Scan offsets from farthest to nearest so the closest hit to ptr wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            grant_idx   = cand;
            any_grant   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_proxy_arbiter.sv
// Round-robin arbiter sharing the 512-bit EECD AXIS command channel between
// NUM_REQ write requesters. One framed beat per granted write, held until
// TREADY; no new grant is issued while a beat is outstanding.
module axis_proxy_arbiter
   import axis_proxy_pkg::*;
#(
   parameter int          NUM_REQ   = 4,
   parameter logic [31:0] MARKER_HI = DEF_MARKER_HI,
   parameter logic [31:0] MARKER_LO = DEF_MARKER_LO
) (
   input  logic                 clk,
   input  logic                 reset,
   axis_proxy_arbiter_if.master bus,
   output logic [31:0]          frames_sent,
   output logic                 busy
);

   localparam int IDX_W = idx_width(NUM_REQ);

   generate
      if (NUM_REQ < 1 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
         $error("axis_proxy_arbiter: NUM_REQ must be in 1..8");
      end
   endgenerate

   arb_state_t             state_reg, state_next;
   logic [FRAME_W-1:0]     tdata_reg, tdata_next;
   logic [31:0]            seq_reg, seq_next;
   logic [31:0]            frames_reg, frames_next;
   logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;

   logic [NUM_REQ-1:0]     grant;
   logic [IDX_W-1:0]       grant_idx;
   logic                   any_grant;
   logic [31:0]            addr_arr [NUM_REQ];
   logic [31:0]            data_arr [NUM_REQ];
   logic [FRAME_W-1:0]     frame;

   // Unflatten the per-requester address/data buses.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = bus.req_addr[32*gi +: 32];
         assign data_arr[gi] = bus.req_data[32*gi +: 32];
      end
   endgenerate

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Accept is offered only in IDLE and never while reset is asserted;
   // it deliberately does not look at TREADY.
   assign bus.req_ready   = (state_reg == IDLE && !reset) ? grant : '0;
   assign bus.AXIS_TDATA  = tdata_reg;
   assign bus.AXIS_TVALID = (state_reg == SEND);
   assign busy            = (state_reg == SEND);
   assign frames_sent     = frames_reg;

   // Assemble the framed beat for whichever requester currently wins.
   always_comb begin
      frame                    = '0;
      frame[DATA_LSB +: 32]    = data_arr[grant_idx];
      frame[ADDR_LSB +: 32]    = addr_arr[grant_idx];
      frame[SEQ_LSB  +: 32]    = seq_reg;
      frame[ID_LSB   +: 8]     = 8'(grant_idx);
      frame[MLO_LSB  +: 32]    = MARKER_LO;
      frame[MHI_LSB  +: 32]    = MARKER_HI;
   end

   // Next-state logic: capture a grant in IDLE, retire the beat on TREADY in SEND.
   always_comb begin
      state_next  = state_reg;
      tdata_next  = tdata_reg;
      seq_next    = seq_reg;
      frames_next = frames_reg;
      rr_ptr_next = rr_ptr_reg;
      case (state_reg)
         IDLE: begin
            if (any_grant) begin
               tdata_next  = frame;
               rr_ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
               state_next  = SEND;
            end
         end
         SEND: begin
            if (bus.AXIS_TREADY) begin
               seq_next    = seq_reg + 32'd1;
               frames_next = frames_reg + 32'd1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any pending beat immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         tdata_reg  <= '0;
         seq_reg    <= '0;
         frames_reg <= '0;
         rr_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         tdata_reg  <= tdata_next;
         seq_reg    <= seq_next;
         frames_reg <= frames_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

endmodule

// File: tb/tb_axis_proxy_arbiter.sv
// Directed bench for axis_proxy_arbiter with NUM_REQ=4: reset state, single
// write, backpressure with a withdrawn request, sparse pointer wrap,
// reset mid-beat, and sustained round-robin.
module tb_axis_proxy_arbiter;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] frames_sent;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] addr_tbl [N];
   logic [31:0] data_tbl [N];

   axis_proxy_arbiter_if #(.NUM_REQ(N)) bus();

   axis_proxy_arbiter #(.NUM_REQ(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.master),
      .frames_sent (frames_sent),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts, reports mismatches, one line per check.
   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = %0h", tag, got);
      end
   endtask

   // Expected beat built independently from hand-chosen field values.
   function automatic logic [511:0] exp_frame(input int id, input logic [31:0] seq);
      logic [511:0] f;
      f = {32'hBEADCAFE, 32'hFADEDBAD, 344'b0, 8'(id), seq, addr_tbl[id], data_tbl[id]};
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      addr_tbl[0] = 32'h0000_1000; data_tbl[0] = 32'hDEAD_BEEF;
      addr_tbl[1] = 32'h0000_2000; data_tbl[1] = 32'h1111_1111;
      addr_tbl[2] = 32'h0000_3000; data_tbl[2] = 32'h2222_2222;
      addr_tbl[3] = 32'h0000_4000; data_tbl[3] = 32'h3333_3333;

      reset           = 1'b1;
      bus.req_valid   = 4'b1111;
      bus.AXIS_TREADY = 1'b0;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[32*i +: 32] = addr_tbl[i];
         bus.req_data[32*i +: 32] = data_tbl[i];
      end

      // Reset state
      tick();
      tick();
      check("rst_tvalid", 512'(bus.AXIS_TVALID), 512'(0));
      check("rst_tdata", bus.AXIS_TDATA, 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_frames", 512'(frames_sent), 512'(0));
      check("rst_ready", 512'(bus.req_ready), 512'(0));
      bus.req_valid = 4'b0000;
      reset = 1'b0;

      // Single request from requester 0
      bus.AXIS_TREADY = 1'b1;
      bus.req_valid   = 4'b0001;
      #1;
      check("single_ready", 512'(bus.req_ready), 512'(4'b0001));
      tick();
      bus.req_valid = 4'b0000;
      check("single_tvalid", 512'(bus.AXIS_TVALID), 512'(1));
      check("single_busy", 512'(busy), 512'(1));
      check("single_low64", 512'(bus.AXIS_TDATA[63:0]), 512'(64'h0000_1000_DEAD_BEEF));
      check("single_frame", bus.AXIS_TDATA, exp_frame(0, 32'd0));
      tick();
      check("single_drop", 512'(bus.AXIS_TVALID), 512'(0));
      check("single_frames", 512'(frames_sent), 512'(1));

      // Backpressure on requester 1's beat, requester 2 pulses mid-SEND
      bus.AXIS_TREADY = 1'b0;
      bus.req_valid   = 4'b0010;
      #1;
      check("bp_ready_idle", 512'(bus.req_ready), 512'(4'b0010));
      tick();
      bus.req_valid = 4'b0000;
      check("bp_frame0", bus.AXIS_TDATA, exp_frame(1, 32'd1));
      for (int c = 0; c < 10; c++) begin
         bus.req_valid = (c == 3) ? 4'b0100 : 4'b0000;
         #1;
         check($sformatf("bp_ready_c%0d", c), 512'(bus.req_ready), 512'(0));
         check($sformatf("bp_tvalid_c%0d", c), 512'(bus.AXIS_TVALID), 512'(1));
         check($sformatf("bp_tdata_c%0d", c), bus.AXIS_TDATA, exp_frame(1, 32'd1));
         tick();
      end
      bus.req_valid = 4'b0000;
      check("bp_frames_held", 512'(frames_sent), 512'(1));
      bus.AXIS_TREADY = 1'b1;
      tick();
      check("bp_release_tvalid", 512'(bus.AXIS_TVALID), 512'(0));
      check("bp_release_frames", 512'(frames_sent), 512'(2));
      check("withdrawn_no_grant", 512'(bus.req_ready), 512'(0));

      // Move pointer to 3 via requester 2, then sparse 1 and 3
      bus.req_valid = 4'b0100;
      #1;
      check("wrap_ready2", 512'(bus.req_ready), 512'(4'b0100));
      tick();
      bus.req_valid = 4'b0000;
      check("wrap_frame2", bus.AXIS_TDATA, exp_frame(2, 32'd2));
      tick();
      bus.req_valid = 4'b1010;
      #1;
      check("wrap_ready_a", 512'(bus.req_ready), 512'(4'b1000));
      tick();
      check("wrap_frame_a", bus.AXIS_TDATA, exp_frame(3, 32'd3));
      tick();
      check("wrap_ready_b", 512'(bus.req_ready), 512'(4'b0010));
      tick();
      check("wrap_frame_b", bus.AXIS_TDATA, exp_frame(1, 32'd4));
      tick();
      check("wrap_ready_c", 512'(bus.req_ready), 512'(4'b1000));
      tick();
      check("wrap_frame_c", bus.AXIS_TDATA, exp_frame(3, 32'd5));
      bus.req_valid = 4'b0000;
      tick();
      check("wrap_frames", 512'(frames_sent), 512'(6));

      // Reset while a beat is stalled
      bus.AXIS_TREADY = 1'b0;
      bus.req_valid   = 4'b0100;
      #1;
      tick();
      bus.req_valid = 4'b0000;
      check("rsend_frame", bus.AXIS_TDATA, exp_frame(2, 32'd6));
      #2;
      reset = 1'b1;
      #1;
      check("rsend_tvalid", 512'(bus.AXIS_TVALID), 512'(0));
      check("rsend_busy", 512'(busy), 512'(0));
      check("rsend_frames", 512'(frames_sent), 512'(0));
      check("rsend_tdata", bus.AXIS_TDATA, 512'(0));
      tick();
      reset = 1'b0;

      // Sustained round-robin with all requesters valid
      bus.AXIS_TREADY = 1'b1;
      bus.req_valid   = 4'b1111;
      #1;
      for (int b = 0; b < 6; b++) begin
         check($sformatf("rr_ready_b%0d", b), 512'(bus.req_ready), 512'(4'b0001 << (b % 4)));
         tick();
         check($sformatf("rr_frame_b%0d", b), bus.AXIS_TDATA, exp_frame(b % 4, 32'(b)));
         tick();
         check($sformatf("rr_gap_b%0d", b), 512'(bus.AXIS_TVALID), 512'(0));
      end
      bus.req_valid = 4'b0000;
      tick();
      check("rr_frames", 512'(frames_sent), 512'(6));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
